// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, NOP encoding and the {pc, instr} entry type for the fetch stage
package fetch_stage_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/grant and in-order response bus
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               gnt;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;
    modport master(output req, addr, input gnt, rvalid, rdata);
    modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/clear and occupancy count
module fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        wp_d = clear_i ? '0 : push_i ? inc(wp_q) : wp_q;
        rp_d = clear_i ? '0 : pop_i ? inc(rp_q) : rp_q;
        cnt_d = clear_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wp_q] <= din_i;
    end
    assign dout_o = mem_q[rp_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch with flush/redirect and IF/ID register
// FETCH_PERF_CNT_EN adds perf_fetched_o / perf_bubble_o counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [PC_W-1:0]    branch_target_i,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_bubble_o
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = CW + 2;
    localparam fetch_entry_t BUBBLE = '{pc: '0, instr: NOP_INSTR};
    logic [PC_W-1:0] fpc_q, fpc_d;
    logic [CW-1:0] kill_q, kill_d, pcf_cnt, buf_cnt;
    logic started_q, started_d;
    fetch_entry_t ifid_q, ifid_d, buf_head, rsp;
    logic [PC_W-1:0] pcf_head;
    logic [TW-1:0] used;
    logic grant, stale, rsp_ok, load, buf_empty, buf_push, buf_pop;
    // stale in-flight requests still hold credits, which bounds kill_q by DEPTH
    assign used = TW'(pcf_cnt) + TW'(kill_q) + TW'(buf_cnt);
    assign imem.req = started_q && !flush_i && used < TW'(DEPTH);
    assign imem.addr = fpc_q;
    assign grant = imem.req && imem.gnt;
    assign stale = imem.rvalid && kill_q != '0;
    assign rsp_ok = imem.rvalid && kill_q == '0 && pcf_cnt != '0 && !flush_i;
    assign load = !stall_i && !flush_i;
    assign buf_empty = buf_cnt == '0;
    assign buf_pop = load && !buf_empty;
    assign buf_push = rsp_ok && !(load && buf_empty);
    assign rsp = '{pc: pcf_head, instr: imem.rdata};
    always_comb begin
        started_d = 1'b1;
        fpc_d = flush_i ? branch_target_i : grant ? fpc_q + PC_W'(4) : fpc_q;
        kill_d = flush_i ? kill_q + pcf_cnt - CW'(imem.rvalid && (kill_q != '0 || pcf_cnt != '0))
                         : kill_q - CW'(stale);
        ifid_d = flush_i ? BUBBLE : stall_i ? ifid_q : !buf_empty ? buf_head : rsp_ok ? rsp : BUBBLE;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fpc_q <= RESET_PC;
            kill_q <= '0;
            started_q <= 1'b0;
            ifid_q <= BUBBLE;
        end else begin
            fpc_q <= fpc_d;
            kill_q <= kill_d;
            started_q <= started_d;
            ifid_q <= ifid_d;
        end
    end
    fetch_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_pc_fifo (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .push_i(grant), .pop_i(rsp_ok), .clear_i(flush_i),
        .din_i(fpc_q), .dout_o(pcf_head), .count_o(pcf_cnt)
    );
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .push_i(buf_push), .pop_i(buf_pop), .clear_i(flush_i),
        .din_i(rsp), .dout_o(buf_head), .count_o(buf_cnt)
    );
    assign instr_o = ifid_q.instr;
    assign pc_o = ifid_q.pc;
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem.rvalid |-> (pcf_cnt != '0 || kill_q != '0));
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d, bubble_q, bubble_d;
    always_comb begin
        fetched_d = fetched_q + 32'(load && (!buf_empty || rsp_ok));
        bubble_d = bubble_q + 32'(load && buf_empty && !rsp_ok);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetched_q <= '0;
            bubble_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubble_q <= bubble_d;
        end
    end
    assign perf_fetched_o = fetched_q;
    assign perf_bubble_o = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a queue-level reference model of fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] instr, pc, instr2, pc2;
    always #5 clk = ~clk;
    fetch_stage_if bus();
    fetch_stage_if bus2();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf, pb, pf2, pb2;
`endif
    fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .branch_target_i(target),
        .imem(bus.master), .instr_o(instr), .pc_o(pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_o(pf), .perf_bubble_o(pb)
`endif
    );
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(1'b0), .flush_i(1'b0), .branch_target_i(32'h0),
        .imem(bus2.master), .instr_o(instr2), .pc_o(pc2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_o(pf2), .perf_bubble_o(pb2)
`endif
    );
    typedef struct packed {logic [31:0] pc; logic stale;} ot_t;
    ot_t out_q[$];
    fetch_entry_t buf_q[$];
    logic [31:0] m_fpc, m_pc, m_instr, m_fetched, m_bubbles;
    bit m_started;
    logic [31:0] mq_addr[$];
    int mq_due[$];
    int cyc = 0, lat = 1, checks = 0, passed = 0;
    logic [31:0] exp2_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    logic exp2_req [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic logic [31:0] f_instr(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        out_q.delete(); buf_q.delete(); mq_addr.delete(); mq_due.delete();
        m_fpc = 32'h100; m_pc = '0; m_instr = NOP_INSTR; m_fetched = '0; m_bubbles = '0;
        m_started = 0;
    endtask

    // one clock cycle: drive inputs and memory, compare DUT to model, advance model
    task automatic step(input bit s, input bit f, input logic [31:0] t, input bit g);
        bit m_req, rv, dv;
        logic [31:0] dpc;
        ot_t ot;
        fetch_entry_t e;
        @(negedge clk);
        cyc++;
        stall = s; flush = f; target = t; bus.gnt = g;
        rv = mq_addr.size() > 0 && mq_due[0] <= cyc;
        bus.rvalid = rv;
        bus.rdata = 32'hDEAD_BEEF;
        if (rv) begin
            bus.rdata = f_instr(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        #1;
        m_req = m_started && !f && (out_q.size() + buf_q.size() < DEPTH);
        chk("req", 32'(bus.req), 32'(m_req));
        chk("addr", bus.addr, m_fpc);
        chk("pc_o", pc, m_pc);
        chk("instr_o", instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", pf, m_fetched);
        chk("perf_bubble", pb, m_bubbles);
`endif
        if (cyc <= 5) begin
            chk("wrap_req", 32'(bus2.req), 32'(exp2_req[cyc-1]));
            chk("wrap_addr", bus2.addr, exp2_addr[cyc-1]);
        end
        if (bus.req && g) begin
            mq_addr.push_back(bus.addr);
            mq_due.push_back(cyc + lat);
        end
        dv = 0; dpc = '0;
        if (rv && out_q.size() > 0) begin
            ot = out_q.pop_front();
            if (!ot.stale && !f) begin dv = 1; dpc = ot.pc; end
        end
        if (f) begin
            foreach (out_q[i]) out_q[i].stale = 1'b1;
            buf_q.delete();
            m_pc = '0; m_instr = NOP_INSTR; m_fpc = t;
        end else begin
            if (m_req && g) begin out_q.push_back('{m_fpc, 1'b0}); m_fpc += 32'd4; end
            if (s) begin
                if (dv) buf_q.push_back('{dpc, f_instr(dpc)});
            end else if (buf_q.size() > 0) begin
                e = buf_q.pop_front();
                m_pc = e.pc; m_instr = e.instr; m_fetched++;
                if (dv) buf_q.push_back('{dpc, f_instr(dpc)});
            end else if (dv) begin
                m_pc = dpc; m_instr = f_instr(dpc); m_fetched++;
            end else begin
                m_pc = '0; m_instr = NOP_INSTR; m_bubbles++;
            end
        end
        m_started = 1;
    endtask

    initial begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus2.gnt = 1'b1; bus2.rvalid = 1'b0; bus2.rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.req), 32'h0);
        chk("rst_addr", bus.addr, 32'h100);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr2", bus2.addr, 32'hFFFF_FFF8);
        chk("rst_pc2", pc2, 32'h0);
        chk("rst_instr2", instr2, NOP_INSTR);
        rst_n = 1'b1;
        #1 chk("rel_req", 32'(bus.req), 32'h0);
        m_started = 1;
        // streaming with a 1-cycle memory
        step(0, 0, 0, 1); chk("seq_a0", bus.addr, 32'h100);
        step(0, 0, 0, 1); chk("seq_a1", bus.addr, 32'h104);
        step(0, 0, 0, 1); chk("seq_a2", bus.addr, 32'h108); chk("first_pc", pc, 32'h100);
        step(0, 0, 0, 1); chk("second_pc", pc, 32'h104);
        repeat (2) step(0, 0, 0, 1);
        // stall fills the buffer until credits run out
        repeat (5) step(1, 0, 0, 1);
        chk("stall_req", 32'(bus.req), 32'h0);
        chk("stall_pc", pc, 32'h110);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1); chk("drain_pc0", pc, 32'h114);
        step(0, 0, 0, 1); chk("drain_pc1", pc, 32'h118);
        step(0, 0, 0, 1); chk("drain_pc2", pc, 32'h11C);
        // grant withheld: request and address hold
        lat = 4;
        repeat (3) step(0, 0, 0, 0);
        chk("hold_req", 32'(bus.req), 32'h1);
        chk("hold_addr", bus.addr, 32'h128);
        // two slow requests outstanding, then flush
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 32'h400, 1); chk("flush_req", 32'(bus.req), 32'h0);
        step(0, 0, 0, 1); chk("flush_bubble", pc, 32'h0); chk("flush_addr", bus.addr, 32'h400);
        step(0, 0, 0, 1);
        lat = 1;
        step(0, 0, 0, 1); chk("redirect_req", 32'(bus.req), 32'h1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1); chk("target_pc", pc, 32'h400); chk("target_instr", instr, f_instr(32'h400));
        step(0, 0, 0, 1);
        // flush and stall together
        step(1, 1, 32'h800, 1); chk("fs_pc_before", pc, 32'h408);
        step(0, 0, 0, 1);
        chk("fs_pc", pc, 32'h0); chk("fs_instr", instr, NOP_INSTR);
        chk("fs_addr", bus.addr, 32'h800); chk("fs_req", 32'(bus.req), 32'h1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1); chk("fs_target_pc", pc, 32'h800);
        // mixed stall/grant pattern
        for (int i = 0; i < 16; i++) step(i % 5 == 2, 0, 0, i % 3 != 0);
        // asynchronous reset mid-operation
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.req), 32'h0);
        chk("mid_rst_addr", bus.addr, 32'h100);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instr, NOP_INSTR);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_perf", pf, 32'h0);
`endif
        bus.rvalid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel2_req", 32'(bus.req), 32'h0);
        m_started = 1;
        repeat (6) step(0, 0, 0, 1);
        chk("post_rst_pc", pc, 32'h10C);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
